tick_sched: RTL and testbench
=============================

# tick_sched

Programmable timebase controller that configures, starts, stops and counts runs of an internal clock divider. Sits between the system control logic and the timebase consumers (display scan, debounce, LED blink). It replaces hard-wired divisor constants with a run-time configuration handshake, one-shot or continuous tick runs, and a done notification. Defaults give 50 MHz → 1 kHz.

## Interface
- DIVW, 20, width of divisor and prescale counter
- CNTW, 16, width of run length and tick counter
- DIV_DEFAULT, 50_000, divisor loaded at reset (clocks per tick)

- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- cfg_valid  input  1  configuration offer
- cfg_ready  output  1  high when configuration can be accepted (state IDLE)
- cfg_div  input  DIVW  clocks per tick; legal range ≥ 2
- cfg_count  input  CNTW  ticks per run; 0 = continuous
- cfg_err  output  1  one-cycle pulse: offered cfg_div < 2, config rejected
- start  input  1  begin a run (sampled in IDLE only)
- stop  input  1  abort a run
- tick  output  1  one-cycle pulse, once per divisor period
- clk_out  output  1  divided square wave, 0 when not running
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after a finite run completes
- tick_cnt  output  CNTW  ticks elapsed in current or last run

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: tick=0, clk_out=0, busy=0, done=0, cfg_err=0, tick_cnt=0, cfg_ready=1; divisor register=DIV_DEFAULT, count register=0 (continuous), prescale counter=0.
- Config handshake: transfer when cfg_valid && cfg_ready. If cfg_div ≥ 2, load divisor and count registers at that edge. Otherwise keep the old values and pulse cfg_err in the next cycle. No transfer outside IDLE. cfg_valid is not an error there and no pulse is produced.
- IDLE: start → RUN. At the same edge: prescale counter=0, tick_cnt=0. A config transfer and start on the same edge: the new config applies to this run. A rejected config with start: the run proceeds with the old config. stop has priority over start, so start is ignored if stop=1.
- RUN: prescale counter counts 0..div−1 and wraps to 0. tick=1 in the cycle where counter==div−1. On that same edge tick_cnt increments, wrapping mod 2^CNTW.
- clk_out = 1 when counter ≥ div>>1, else 0. Low for floor(div/2) cycles, then high for the rest of the period. Odd div gives a longer high phase.
- Finite run (count N≠0): on the tick where tick_cnt becomes N, go to DONE. Continuous (count=0): never leaves RUN except via stop or RST.
- stop in RUN → IDLE next edge. No done pulse. tick_cnt holds its value. A tick coinciding with stop is still emitted and counted.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start and stop are ignored in DONE.
- start in RUN is ignored.
- tick_cnt holds after a run ends until the next start.
- RST mid-run: IDLE next cycle, all reset values apply, no done pulse, configuration reverts to defaults.

## Timing
- All outputs are registered or derived from registered state. No combinational input→output paths except cfg_ready, which depends on state only.
- Start sampled at edge E0. busy=1 from E0+1. First tick is asserted in the cycle following edge E0+div−1, i.e. div cycles of RUN precede tick inclusive.
- Tick period is exactly div cycles with no drift across wraps.
- Finite run of N ticks: tick N in cycle T. done=1 in cycle T+1, busy falls at T+1. cfg_ready=1 from T+2.
- cfg_err is asserted one cycle after the rejected transfer.

## Test plan
- Reset defaults: hold RST 3 cycles → all outputs at reset values, cfg_ready=1. Start with no config → tick every 50_000 cycles, clk_out low 25_000 / high 25_000.
- Finite run: cfg_div=4, cfg_count=3, start → ticks at RUN cycles 4, 8, 12. tick_cnt reads 1, 2, 3. done one cycle after the third tick. busy high for exactly 12 cycles.
- Odd divisor, continuous: cfg_div=5, count=0 → clk_out pattern 0,0,1,1,1 repeating. tick each 5 cycles. No done after 100 ticks.
- Illegal config: cfg_div=1 with cfg_valid in IDLE → cfg_err pulse, registers unchanged; the next run uses the previous divisor. Config offered during RUN → no transfer, no cfg_err.
- Stop/abort: stop at RUN cycle 6 with div=4, count=10 → IDLE next cycle, tick_cnt=1 held, no done. Stop coinciding with a tick → tick emitted and counted. start+stop together in IDLE → stays IDLE.
- Reset mid-run: assert RST during a finite run → busy=0 next cycle, no done, divisor back to DIV_DEFAULT.

Source files
------------

// File: rtl/tick_sched.sv
// Programmable timebase: run-time configurable clock divider with one-shot or
// continuous tick runs, abort, and a completion pulse.
module tick_sched #(
  parameter int DIVW        = 20,
  parameter int CNTW        = 16,
  parameter int DIV_DEFAULT = 50_000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [CNTW-1:0] cfg_count,
  output logic            cfg_err,
  input  logic            start,
  input  logic            stop,
  output logic            tick,
  output logic            clk_out,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] tick_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [DIVW-1:0] div_reg;
  logic [DIVW-1:0] pre_reg;
  logic [CNTW-1:0] count_reg;
  logic [CNTW-1:0] tick_cnt_reg;
  logic            cfg_err_reg;

  logic            at_wrap;
  logic            cfg_take;
  logic            cfg_bad;
  logic [CNTW-1:0] tick_cnt_next;

  assign cfg_ready     = (state_reg == IDLE);
  assign cfg_take      = cfg_valid && cfg_ready;
  assign cfg_bad       = cfg_take && (cfg_div < DIVW'(2));
  assign at_wrap       = (pre_reg == div_reg - DIVW'(1));
  assign tick_cnt_next = tick_cnt_reg + CNTW'(1);

  // Outputs decode registered state only; no input reaches them combinationally.
  assign tick     = (state_reg == RUN) && at_wrap;
  assign clk_out  = (state_reg == RUN) && (pre_reg >= (div_reg >> 1));
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign tick_cnt = tick_cnt_reg;
  assign cfg_err  = cfg_err_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      div_reg      <= DIVW'(DIV_DEFAULT);
      count_reg    <= '0;
      pre_reg      <= '0;
      tick_cnt_reg <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_bad;
      // A config accepted on the start edge is already in effect for that run.
      if (cfg_take && !cfg_bad) begin
        div_reg   <= cfg_div;
        count_reg <= cfg_count;
      end
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            state_reg    <= RUN;
            pre_reg      <= '0;
            tick_cnt_reg <= '0;
          end
        end
        RUN: begin
          pre_reg <= at_wrap ? '0 : pre_reg + DIVW'(1);
          if (at_wrap)
            tick_cnt_reg <= tick_cnt_next;
          // Abort wins over completion: a stopped run never signals done.
          if (stop)
            state_reg <= IDLE;
          else if (at_wrap && (count_reg != '0) && (tick_cnt_next == count_reg))
            state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: defaults, finite/continuous runs, config
// rejection, abort and mid-run reset, against hand-computed expectations.
module tb_tick_sched;

  localparam int DIVW    = 20;
  localparam int CNTW    = 16;
  localparam int DIV_DEF = 12;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [DIVW-1:0] cfg_div = '0;
  logic [CNTW-1:0] cfg_count = '0;
  logic            cfg_err;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            tick;
  logic            clk_out;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] tick_cnt;

  tick_sched #(.DIVW(DIVW), .CNTW(CNTW), .DIV_DEFAULT(DIV_DEF)) dut (
    .CLK(CLK), .RST(RST),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_count(cfg_count), .cfg_err(cfg_err),
    .start(start), .stop(stop),
    .tick(tick), .clk_out(clk_out), .busy(busy), .done(done),
    .tick_cnt(tick_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [63:0] tv, cv, bv, dv, rv;
  logic [CNTW-1:0] c1, c2, c3;
  int ntick;
  logic seen_done, seen_err;

  initial begin
    // Reset defaults
    repeat (3) step();
    check("rst_tick", tick, 0);
    check("rst_clk_out", clk_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    RST = 1'b0;
    step();

    // Default divisor, no config
    $display("run: default divisor %0d, continuous", DIV_DEF);
    start = 1'b1; step(); start = 1'b0;
    check("def_busy", busy, 1);
    check("def_cfg_ready", cfg_ready, 0);
    tv = '0; cv = '0;
    for (int k = 0; k < 24; k++) begin
      tv[k] = tick; cv[k] = clk_out; step();
    end
    check("def_tick_pattern", tv, 64'h0080_0800);
    check("def_clk_out_pattern", cv, 64'h00FC_0FC0);
    stop = 1'b1; step(); stop = 1'b0;
    check("def_stop_busy", busy, 0);
    check("def_stop_tick_cnt", tick_cnt, 2);

    // Finite run, config and start on the same edge
    $display("run: div=4 count=3");
    cfg_valid = 1'b1; cfg_div = 4; cfg_count = 3; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    tv = '0; bv = '0; dv = '0; rv = '0; c1 = '0; c2 = '0; c3 = '0;
    for (int k = 0; k < 14; k++) begin
      if (k == 0) check("fin_tick_cnt_cleared", tick_cnt, 0);
      if (k == 4) c1 = tick_cnt;
      if (k == 8) c2 = tick_cnt;
      if (k == 12) c3 = tick_cnt;
      tv[k] = tick; bv[k] = busy; dv[k] = done; rv[k] = cfg_ready;
      step();
    end
    check("fin_tick_pattern", tv, 64'h0888);
    check("fin_busy_pattern", bv, 64'h0FFF);
    check("fin_done_pattern", dv, 64'h1000);
    check("fin_ready_pattern", rv, 64'h2000);
    check("fin_cnt_after_t1", c1, 1);
    check("fin_cnt_after_t2", c2, 2);
    check("fin_cnt_after_t3", c3, 3);
    check("fin_cnt_held", tick_cnt, 3);

    // Legal config, then rejected one
    $display("cfg: div=5 count=0 accepted, then div=1 rejected");
    cfg_valid = 1'b1; cfg_div = 5; cfg_count = 0;
    step();
    check("cfg_ok_no_err", cfg_err, 0);
    cfg_div = 1;
    step();
    cfg_valid = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    step();
    check("cfg_err_one_cycle", cfg_err, 0);

    // Continuous run with odd divisor; config offered mid-run is ignored
    $display("run: div=5 continuous, 500 cycles");
    start = 1'b1; step(); start = 1'b0;
    tv = '0; cv = '0; ntick = 0; seen_done = 1'b0; seen_err = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (k < 10) begin tv[k] = tick; cv[k] = clk_out; end
      ntick += int'(tick);
      seen_done |= done;
      seen_err  |= cfg_err;
      cfg_valid = (k >= 200 && k < 203);
      cfg_div   = 1;
      step();
    end
    cfg_valid = 1'b0;
    seen_err |= cfg_err;
    check("odd_clk_out_pattern", cv, 64'h039C);
    check("odd_tick_pattern", tv, 64'h0210);
    check("odd_tick_count", ntick, 100);
    check("odd_no_done", seen_done, 0);
    check("odd_no_cfg_err_in_run", seen_err, 0);
    check("odd_tick_cnt", tick_cnt, 100);
    check("odd_still_busy", busy, 1);
    repeat (4) step();
    check("odd_tick_before_stop", tick, 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_on_tick_busy", busy, 0);
    check("stop_on_tick_counted", tick_cnt, 101);
    check("stop_on_tick_no_done", done, 0);

    // Abort at RUN cycle 6
    $display("run: div=4 count=10, stop at cycle 6");
    cfg_valid = 1'b1; cfg_div = 4; cfg_count = 10; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (5) step();
    stop = 1'b1; step(); stop = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_tick_cnt", tick_cnt, 1);
    check("abort_no_done", done, 0);
    step();
    check("abort_no_done_later", done, 0);
    check("abort_cnt_held", tick_cnt, 1);
    check("abort_ready", cfg_ready, 1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle_busy", busy, 0);
    check("start_stop_idle_ready", cfg_ready, 1);
    check("start_stop_idle_cnt", tick_cnt, 1);

    // Reset in the middle of a finite run
    $display("run: div=6 count=5, reset mid-run");
    cfg_valid = 1'b1; cfg_div = 6; cfg_count = 5; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (3) step();
    RST = 1'b1; step(); RST = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tick_cnt", tick_cnt, 0);
    check("mid_rst_ready", cfg_ready, 1);
    step();
    check("mid_rst_no_done_later", done, 0);
    start = 1'b1; step(); start = 1'b0;
    tv = '0;
    for (int k = 0; k < 13; k++) begin
      tv[k] = tick; step();
    end
    check("mid_rst_default_div", tv, 64'h0800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
